// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipe_ctrl packet sequencer: FSM state codes,
// bytes per RGB pixel and the default counter width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam int PIXEL_BYTES   = 3;
    localparam int PKT_W_DEFAULT = 12;

endpackage

// File: rtl/pixel_triplet_cnt.sv
// Groups popped RGB bytes into pixels: a mod-3 phase counter whose wrap
// counts one completed triplet. A trailing partial triplet never reaches
// the triplet count and its phase is dropped by clr.
module pixel_triplet_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int PKT_W = PKT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [PKT_W-1:0] triplets
);

    localparam logic [1:0] LAST_PHASE = 2'(PIXEL_BYTES - 1);

    logic [1:0] phase;

    // Advance the byte phase on each pop; the final byte of a pixel bumps the triplet count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            triplets <= '0;
        end else if (clr) begin
            phase    <= '0;
            triplets <= '0;
        end else if (adv) begin
            if (phase == LAST_PHASE) begin
                phase    <= '0;
                triplets <= triplets + PKT_W'(1);
            end else begin
                phase <= phase + 2'd1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Packet sequencer between the RGB input buffer, the gray converter and the
// gray output buffer. Pops input bytes while streaming/draining, waits for
// the converter to deliver one gray byte per completed pixel, then hands
// the answer to the manager with a one-cycle o_out_last pulse.
// Optional watchdog: define PIPE_CTRL_TIMEOUT_EN to abort a packet that
// stays in DRAIN/FLUSH for TIMEOUT_CYCLES cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PKT_W          = PKT_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_empty,
    input  logic             i_in_last,
    input  logic             i_out_full,
    input  logic             i_out_busy,
    input  logic             i_gray_valid,
    input  logic             i_tmanager_ready,
    output logic             o_enb,
    output logic             o_out_last,
    output logic [PKT_W-1:0] o_packet_size_in_bytes,
    output logic [1:0]       o_state,
    output logic             o_err_overflow,
    output logic             o_err_timeout
);

    localparam logic [PKT_W-1:0] BYTE_MAX = '1;

    state_t           state;
    logic             last_seen;
    logic [PKT_W-1:0] byte_cnt;
    logic [PKT_W-1:0] gray_cnt;
    logic [PKT_W-1:0] triplet_cnt;
    logic             flush_done;
    logic             timeout_hit;
    logic             go_idle;

    function automatic logic [PKT_W-1:0] sat_inc(input logic [PKT_W-1:0] v);
        return (v == BYTE_MAX) ? v : v + PKT_W'(1);
    endfunction

    assign o_enb      = ((state == STREAM) || (state == DRAIN)) && !i_in_empty && !i_out_full;
    assign o_state    = state;
    assign flush_done = (state == FLUSH) && i_tmanager_ready && !i_out_busy;
    // Every return to IDLE (normal hand-off or watchdog abort) restarts the counters
    assign go_idle    = flush_done || timeout_hit;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_timeout;

    assign timeout_hit   = ((state == DRAIN) || (state == FLUSH)) &&
                           (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign o_err_timeout = err_timeout;

    // Watchdog: count cycles spent waiting in DRAIN/FLUSH, sticky flag on expiry
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (((state == DRAIN) || (state == FLUSH)) && !timeout_hit)
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;
            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign o_err_timeout      = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    pixel_triplet_cnt #(
        .PKT_W(PKT_W)
    ) u_triplet (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .clr     (go_idle),
        .adv     (o_enb),
        .triplets(triplet_cnt)
    );

    // Packet FSM, end-of-answer pulse, size capture and the last-byte marker
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state                  <= IDLE;
            o_out_last             <= 1'b0;
            o_packet_size_in_bytes <= '0;
            last_seen              <= 1'b0;
        end else begin
            o_out_last <= go_idle;
            // A marker arriving on the hand-off cycle belongs to the next packet
            if (i_in_last)
                last_seen <= 1'b1;
            else if (go_idle)
                last_seen <= 1'b0;

            if (go_idle) begin
                state <= IDLE;
                if (flush_done && !timeout_hit)
                    o_packet_size_in_bytes <= gray_cnt;
            end else begin
                case (state)
                    IDLE:    if (!i_in_empty) state <= STREAM;
                    STREAM:  if (last_seen) state <= DRAIN;
                    DRAIN:   if (i_in_empty && !o_enb && (gray_cnt == triplet_cnt)) state <= FLUSH;
                    FLUSH:   ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Saturating byte counter with sticky overflow, and the gray byte counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            byte_cnt       <= '0;
            gray_cnt       <= '0;
            o_err_overflow <= 1'b0;
        end else begin
            if (go_idle) begin
                byte_cnt <= '0;
                gray_cnt <= '0;
            end else begin
                if (o_enb)
                    byte_cnt <= sat_inc(byte_cnt);
                if (i_gray_valid)
                    gray_cnt <= gray_cnt + PKT_W'(1);
                if (o_enb && (byte_cnt == BYTE_MAX))
                    o_err_overflow <= 1'b1;
            end
        end
    end

endmodule
